// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the divide sequencer: FSM encodings, HILO packing
// positions and the zero-divisor fast-path constant.
package div_sequencer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int HI_MSB = 63;
  localparam int HI_LSB = 32;
  localparam int LO_MSB = 31;
  localparam int LO_LSB = 0;

  localparam logic [31:0] ZERO_FAST_LO = 32'hFFFF_FFFF;

  function automatic logic [63:0] pack_hilo(input logic [31:0] hi, input logic [31:0] lo);
    logic [63:0] packed_val;
    packed_val                 = '0;
    packed_val[HI_MSB:HI_LSB]  = hi;
    packed_val[LO_MSB:LO_LSB]  = lo;
    return packed_val;
  endfunction

endpackage

// File: rtl/div_sequencer_watchdog.sv
// div_watchdog: clearable up-counter whose terminal-count flag rises in the
// TIMEOUT_CYCLES-th enabled cycle after a clear. TIMEOUT_CYCLES = 0 disables it.
module div_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign tc = 1'b0;
    end else begin : g_on
      localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] TC_VALUE = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_reg;

      always_ff @(posedge clk) begin
        if (rst || clr) begin
          count_reg <= '0;
        end else if (en && !tc) begin
          count_reg <= count_reg + 1'b1;
        end
      end

      // Count holds the number of enabled cycles already elapsed, so the
      // flag lands in the TIMEOUT_CYCLES-th one.
      assign tc = en && (count_reg == TC_VALUE);
    end
  endgenerate

endmodule

// File: rtl/div_sequencer.sv
// Execute-stage controller for the multi-cycle divider: start/annul handshake,
// pipeline stall, HILO write-back, flush and watchdog. Optional macro
// DIV_SEQ_ZERO_FAST_EN resolves zero divisors without starting the divider.
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic        op_signed_i,
  input  logic [31:0] op_a_i,
  input  logic [31:0] op_b_i,
  input  logic        flush_i,
  input  logic        ex_ready_i,
  output logic        div_start_o,
  output logic        div_signed_o,
  output logic [31:0] div_a_o,
  output logic [31:0] div_b_o,
  output logic        div_annul_o,
  input  logic [63:0] div_result_i,
  input  logic        div_ready_i,
  output logic        stall_o,
  output logic        hilo_we_o,
  output logic [63:0] hilo_wdata_o,
  output logic        timeout_o
);

  logic [1:0]  state_reg, state_next;
  logic [31:0] a_reg, b_reg;
  logic        signed_reg;
  logic [63:0] result_reg;

  logic is_idle, is_busy, is_done;
  logic accept, zero_fast, capture, annul, wd_tc;

  div_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (!is_busy),
    .en  (is_busy),
    .tc  (wd_tc)
  );

  always_comb begin
    is_idle = (state_reg == ST_IDLE);
    is_busy = (state_reg == ST_BUSY);
    is_done = (state_reg == ST_DONE);
    accept  = is_idle && op_valid_i && !flush_i;
`ifdef DIV_SEQ_ZERO_FAST_EN
    zero_fast = accept && (op_b_i == 32'd0);
`else
    zero_fast = 1'b0;
`endif
    // Flush outranks the watchdog, which outranks a divider result.
    annul   = is_busy && (flush_i || wd_tc);
    capture = is_busy && !annul && div_ready_i;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = zero_fast ? ST_DONE : ST_BUSY;
      ST_BUSY: begin
        if (annul)        state_next = ST_IDLE;
        else if (capture) state_next = ST_DONE;
      end
      ST_DONE: if (ex_ready_i || flush_i) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      result_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg      <= op_a_i;
        b_reg      <= op_b_i;
        signed_reg <= op_signed_i;
      end
      if (capture) begin
        result_reg <= div_result_i;
      end else if (zero_fast) begin
        result_reg <= pack_hilo(op_a_i, ZERO_FAST_LO);
      end
    end
  end

  assign div_start_o  = is_busy && !annul;
  assign div_signed_o = signed_reg;
  assign div_a_o      = a_reg;
  assign div_b_o      = b_reg;
  assign div_annul_o  = annul;
  assign timeout_o    = is_busy && !flush_i && wd_tc;
  assign stall_o      = accept || is_busy;
  // DONE holds the result until EX advances; the held op_valid_i is ignored here.
  assign hilo_we_o    = is_done && ex_ready_i && !flush_i;
  assign hilo_wdata_o = result_reg;

endmodule
